// File: rtl/video_capture.sv
// Video capture front end: registers the sync inputs, frames pixels with a
// four-state capture FSM, scales each colour channel to OUT_W bits and queues
// {R,G,B, sof, sol} in a small FIFO drained by a valid/ready consumer.
module video_capture #(
    parameter int COLOR_W    = 3,
    parameter int OUT_W      = 8,
    parameter int SCALE_MODE = 0,
    parameter int FIFO_DEPTH = 16,
    parameter int NUM_FRAMES = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               HSYNC_n,
    input  logic               VSYNC_n,
    input  logic [COLOR_W-1:0] VIDEO_R,
    input  logic [COLOR_W-1:0] VIDEO_G,
    input  logic [COLOR_W-1:0] VIDEO_B,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [3*OUT_W-1:0] pix_data,
    output logic               pix_sof,
    output logic               pix_sol,
    output logic [15:0]        frame_count,
    output logic               overflow,
    output logic               done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = 3*OUT_W + 2;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

    state_t state_q, state_d;

    // Stage 1: registered syncs, their previous values, aligned colour
    logic               hs_q, hs_d, vs_q, vs_d;
    logic               hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [COLOR_W-1:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
    logic               sof_pend_q, sof_pend_d, sol_pend_q, sol_pend_d;
    logic [15:0]        frame_count_q, frame_count_d;

    // Stage 2: scaled pixel waiting to be written into the FIFO
    logic               s2_push_q, s2_push_d;
    logic [3*OUT_W-1:0] s2_data_q, s2_data_d;
    logic               s2_sof_q, s2_sof_d, s2_sol_q, s2_sol_d;

    // FIFO bookkeeping
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [DW-1:0]      fifo_mem [FIFO_DEPTH];
    logic [DW-1:0]      head;

    logic vs_rise, vs_fall, hs_rise, capture_push, enter_capture;
    logic fifo_full, fifo_pop, fifo_wr;

    logic [COLOR_W-1:0] chan_in  [3];
    logic [OUT_W-1:0]   chan_out [3];

    // Widen one channel: zero-fill shift, or MSB-first replication of the input bits
    function automatic logic [OUT_W-1:0] scale_chan(input logic [COLOR_W-1:0] c);
        logic [OUT_W-1:0] r;
        r = OUT_W'(c) << (OUT_W - COLOR_W);
        if (SCALE_MODE == 1) begin
            for (int j = 0; j < OUT_W; j++) begin
                r[OUT_W-1-j] = c[COLOR_W-1-(j % COLOR_W)];
            end
        end
        return r;
    endfunction

    assign chan_in[0] = r1_q;
    assign chan_in[1] = g1_q;
    assign chan_in[2] = b1_q;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_scale
            assign chan_out[gi] = scale_chan(chan_in[gi]);
        end
    endgenerate

    assign vs_rise = vs_q & ~vs_prev_q;
    assign vs_fall = ~vs_q & vs_prev_q;
    assign hs_rise = hs_q & ~hs_prev_q;

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state and frame counting; enable low aborts to IDLE except in DONE
    always_comb begin
        state_d       = state_q;
        frame_count_d = frame_count_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (!enable)     state_d = IDLE;
                else if (vs_rise) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (vs_fall) begin
                    frame_count_d = frame_count_q + 16'd1;
                    if (NUM_FRAMES != 0 && frame_count_d == 16'(NUM_FRAMES))
                        state_d = DONE;
                    else
                        state_d = WAIT_VS;
                end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
        enter_capture = (state_q == WAIT_VS) && (state_d == CAPTURE);
    end

    // Sync capture, sof/sol tracking, scaling stage and FIFO pointer arithmetic
    always_comb begin
        hs_d      = HSYNC_n;
        vs_d      = VSYNC_n;
        hs_prev_d = hs_q;
        vs_prev_d = vs_q;
        r1_d      = VIDEO_R;
        g1_d      = VIDEO_G;
        b1_d      = VIDEO_B;

        capture_push = (state_q == CAPTURE) && hs_q && vs_q;

        sof_pend_d = sof_pend_q;
        if (enter_capture)     sof_pend_d = 1'b1;
        else if (capture_push) sof_pend_d = 1'b0;

        sol_pend_d = sol_pend_q;
        if (capture_push)  sol_pend_d = 1'b0;
        else if (hs_rise)  sol_pend_d = 1'b1;

        s2_push_d = capture_push;
        s2_data_d = {chan_out[0], chan_out[1], chan_out[2]};
        s2_sof_d  = sof_pend_q;
        s2_sol_d  = sol_pend_q | hs_rise | sof_pend_q;

        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        fifo_full = (count_q == FULL_CNT);
        fifo_pop  = pix_valid & pix_ready;
        fifo_wr   = s2_push_q & (~fifo_full | fifo_pop);

        wr_ptr_d = fifo_wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = fifo_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (fifo_wr && !fifo_pop)      count_d = count_q + (AW+1)'(1);
        else if (!fifo_wr && fifo_pop) count_d = count_q - (AW+1)'(1);

        overflow_d = overflow_q | (s2_push_q & fifo_full & ~fifo_pop);
    end

    // Pipeline and FIFO control registers; syncs reset to their inactive (high) level
    always_ff @(posedge clock) begin
        if (reset) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            r1_q          <= '0;
            g1_q          <= '0;
            b1_q          <= '0;
            sof_pend_q    <= 1'b0;
            sol_pend_q    <= 1'b0;
            frame_count_q <= '0;
            s2_push_q     <= 1'b0;
            s2_data_q     <= '0;
            s2_sof_q      <= 1'b0;
            s2_sol_q      <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            r1_q          <= r1_d;
            g1_q          <= g1_d;
            b1_q          <= b1_d;
            sof_pend_q    <= sof_pend_d;
            sol_pend_q    <= sol_pend_d;
            frame_count_q <= frame_count_d;
            s2_push_q     <= s2_push_d;
            s2_data_q     <= s2_data_d;
            s2_sof_q      <= s2_sof_d;
            s2_sol_q      <= s2_sol_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clock) begin
        if (fifo_wr && !reset) fifo_mem[wr_ptr_q] <= {s2_data_q, s2_sof_q, s2_sol_q};
    end

    // Head of queue is shown directly so a pixel is visible the cycle after its write
    assign head        = fifo_mem[rd_ptr_q];
    assign pix_valid   = (count_q != '0);
    assign pix_data    = pix_valid ? head[DW-1:2] : '0;
    assign pix_sof     = pix_valid & head[1];
    assign pix_sol     = pix_valid & head[0];
    assign frame_count = frame_count_q;
    assign overflow    = overflow_q;
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture: two instances share stimulus,
// dut0 = zero-fill scaling, 4-deep FIFO, unlimited frames;
// dut1 = replication scaling, 16-deep FIFO, stops after 2 frames.
module tb_video_capture;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, enable, hs, vs, pix_ready;
    logic [2:0] vr, vg, vb;

    logic        v0, sof0, sol0, ov0, done0;
    logic [23:0] d0;
    logic [15:0] fc0;
    logic        v1, sof1, sol1, ov1, done1;
    logic [23:0] d1;
    logic [15:0] fc1;

    int checks = 0;
    int errors = 0;

    logic [25:0] popq [$];

    video_capture #(.COLOR_W(3), .OUT_W(8), .SCALE_MODE(0), .FIFO_DEPTH(4), .NUM_FRAMES(0)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .HSYNC_n(hs), .VSYNC_n(vs),
        .VIDEO_R(vr), .VIDEO_G(vg), .VIDEO_B(vb),
        .pix_valid(v0), .pix_ready(pix_ready), .pix_data(d0), .pix_sof(sof0), .pix_sol(sol0),
        .frame_count(fc0), .overflow(ov0), .done(done0)
    );

    video_capture #(.COLOR_W(3), .OUT_W(8), .SCALE_MODE(1), .FIFO_DEPTH(16), .NUM_FRAMES(2)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .HSYNC_n(hs), .VSYNC_n(vs),
        .VIDEO_R(vr), .VIDEO_G(vg), .VIDEO_B(vb),
        .pix_valid(v1), .pix_ready(pix_ready), .pix_data(d1), .pix_sof(sof1), .pix_sol(sol1),
        .frame_count(fc1), .overflow(ov1), .done(done1)
    );

    // Record every dut0 pop, sampled mid-cycle ahead of the edge that performs it
    always @(negedge clock) begin
        if (v0 && pix_ready) popq.push_back({d0, sof0, sol0});
    end

    typedef struct {
        logic [2:0]  r, g, b;
        logic [23:0] exp0, exp1;
        logic        sof, sol;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic v, input logic [2:0] r,
                         input logic [2:0] g, input logic [2:0] b);
        hs = h; vs = v; vr = r; vg = g; vb = b;
    endtask

    task automatic start_frame();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
        tick(); tick();
        drive(1'b0, 1'b1, 3'd0, 3'd0, 3'd0);
        tick(); tick();
    endtask

    task automatic end_frame();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
        tick(); tick(); tick();
    endtask

    initial begin
        logic [25:0] act;
        logic [25:0] exp;

        vecs[0] = '{r:3'd7, g:3'd5, b:3'd0, exp0:24'hE0A000, exp1:24'hFFB600, sof:1'b1, sol:1'b1};
        vecs[1] = '{r:3'd1, g:3'd2, b:3'd3, exp0:24'h204060, exp1:24'h24496D, sof:1'b0, sol:1'b0};
        vecs[2] = '{r:3'd4, g:3'd6, b:3'd7, exp0:24'h80C0E0, exp1:24'h92DBFF, sof:1'b0, sol:1'b0};
        vecs[3] = '{r:3'd0, g:3'd0, b:3'd0, exp0:24'h000000, exp1:24'h000000, sof:1'b0, sol:1'b0};
        vecs[4] = '{r:3'd5, g:3'd3, b:3'd1, exp0:24'hA06020, exp1:24'hB66D24, sof:1'b0, sol:1'b0};

        reset = 1'b1; enable = 1'b0; pix_ready = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
        tick(); tick(); tick();
        check("rst_valid", v0, 0);
        check("rst_data", d0, 0);
        check("rst_sof_sol", {sof0, sol0}, 0);
        check("rst_fcount", fc0, 0);
        check("rst_overflow", ov0, 0);
        check("rst_done", done1, 0);
        reset = 1'b0;

        // Scaling table: one line, one pixel per cycle, consumer always ready
        enable = 1'b1; pix_ready = 1'b1;
        start_frame();
        for (int i = 0; i < 7; i++) begin
            if (i < 5) drive(1'b1, 1'b1, vecs[i].r, vecs[i].g, vecs[i].b);
            else       drive(1'b0, 1'b1, 3'd0, 3'd0, 3'd0);
            tick();
            if (i == 1) check("latency_not_yet", v0, 0);
            if (i >= 2) begin
                $display("vec %0d rgb=%0d,%0d,%0d d0=%h d1=%h", i-2, vecs[i-2].r, vecs[i-2].g, vecs[i-2].b, d0, d1);
                check("vec_valid", v0, 1);
                check("vec_mode0", d0, vecs[i-2].exp0);
                check("vec_mode1", d1, vecs[i-2].exp1);
                check("vec_sof_sol", {sof0, sol0, sof1, sol1},
                      {vecs[i-2].sof, vecs[i-2].sol, vecs[i-2].sof, vecs[i-2].sol});
            end
        end
        end_frame();
        check("frame1_fc0", fc0, 1);
        check("frame1_fc1", fc1, 1);
        check("frame1_not_done", done1, 0);

        // Framing: two lines of four pixels
        popq.delete();
        start_frame();
        for (int ln = 0; ln < 2; ln++) begin
            for (int p = 0; p < 4; p++) begin
                drive(1'b1, 1'b1, 3'(ln*4 + p), 3'd0, 3'd0);
                tick();
            end
            drive(1'b0, 1'b1, 3'd0, 3'd0, 3'd0);
            tick(); tick();
        end
        end_frame();
        tick(); tick(); tick(); tick();
        check("frame_pops", popq.size(), 8);
        for (int k = 0; k < 8; k++) begin
            exp = {3'(k), 21'd0, (k == 0), (k == 0 || k == 4)};
            act = (k < popq.size()) ? popq[k] : '1;
            $display("pop %0d data=%h sof=%0d sol=%0d", k, act[25:2], act[1], act[0]);
            check("frame_pop", act, exp);
        end
        check("frame2_fc0", fc0, 2);
        check("frame2_fc1", fc1, 2);
        check("frame2_done", done1, 1);

        // Backpressure on the 4-deep FIFO, including a push while full with a pop
        pix_ready = 1'b0;
        popq.delete();
        start_frame();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 3'(k+1), 3'd0, 3'd0);
            tick();
        end
        drive(1'b0, 1'b1, 3'd0, 3'd0, 3'd0);
        tick(); tick(); tick(); tick();
        check("full_valid", v0, 1);
        check("full_head", d0, 24'h200000);
        check("full_sof", sof0, 1);
        check("full_no_overflow", ov0, 0);
        check("done_no_push", v1, 0);
        tick(); tick();
        check("stall_hold", d0, 24'h200000);

        drive(1'b1, 1'b1, 3'd5, 3'd0, 3'd0);
        tick();
        drive(1'b0, 1'b1, 3'd0, 3'd0, 3'd0);
        tick();
        pix_ready = 1'b1;
        tick();
        pix_ready = 1'b0;
        check("push_pop_full_ovf", ov0, 0);
        check("push_pop_full_head", d0, 24'h400000);

        drive(1'b1, 1'b1, 3'd6, 3'd0, 3'd0);
        tick();
        drive(1'b0, 1'b1, 3'd0, 3'd0, 3'd0);
        tick(); tick(); tick();
        check("drop_overflow", ov0, 1);
        check("done_still_empty", v1, 0);
        end_frame();
        pix_ready = 1'b1;
        tick(); tick(); tick(); tick(); tick(); tick();
        check("bp_pops", popq.size(), 5);
        for (int k = 0; k < 5; k++) begin
            act = (k < popq.size()) ? popq[k] : '1;
            $display("bp pop %0d data=%h", k, act[25:2]);
            check("bp_order", act[25:2], {3'(k+1), 21'd0});
        end
        check("frame3_fc0", fc0, 3);
        check("frame3_fc1_held", fc1, 2);
        check("frame3_done_held", done1, 1);

        // Reset with entries queued mid-line
        pix_ready = 1'b0;
        start_frame();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 3'(k+1), 3'd0, 3'd0);
            tick();
        end
        drive(1'b0, 1'b1, 3'd0, 3'd0, 3'd0);
        tick(); tick(); tick(); tick();
        check("pre_reset_valid", v0, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_valid", v0, 0);
        check("mid_reset_fcount", fc0, 0);
        check("mid_reset_overflow", ov0, 0);
        check("mid_reset_data", d0, 0);
        check("mid_reset_done", done1, 0);

        // Pixels before a fresh VSYNC_n rise must not be captured
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 3'd7, 3'd7, 3'd7);
            tick();
        end
        drive(1'b0, 1'b1, 3'd0, 3'd0, 3'd0);
        tick(); tick(); tick(); tick();
        check("no_capture_before_vs", v0, 0);

        start_frame();
        drive(1'b1, 1'b1, 3'd3, 3'd2, 3'd1);
        tick();
        drive(1'b0, 1'b1, 3'd0, 3'd0, 3'd0);
        tick(); tick(); tick();
        check("restart_valid", v0, 1);
        check("restart_data", d0, 24'h604020);
        check("restart_sof", {sof0, sol0}, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
